// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl: codec read/write sequencer with a priming sample FIFO,
// output source select (passthrough/mute/tone/swap) and overflow/underrun counters
module audio_stream_ctrl #(
   parameter int          DEPTH       = 16,
   parameter int          PRIME_LEVEL = 8,
   parameter int          TONE_HALF   = 24,
   parameter logic [23:0] TONE_AMP    = 24'h200000,
   parameter int          CNT_W       = 16
) (
   input  logic                     CLOCK_50,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [1:0]               mode,
   input  logic                     read_ready,
   input  logic                     write_ready,
   input  logic [23:0]              readdata_left,
   input  logic [23:0]              readdata_right,
   output logic                     read,
   output logic                     write,
   output logic [23:0]              writedata_left,
   output logic [23:0]              writedata_right,
   output logic [$clog2(DEPTH):0]   fill,
   output logic [1:0]               state,
   output logic [CNT_W-1:0]         overflow_cnt,
   output logic [CNT_W-1:0]         underrun_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TONE_HALF + 1);
   localparam logic [AW:0]   FULL_LV   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   PRIME_LV  = (AW+1)'(PRIME_LEVEL);
   localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

   typedef enum logic [1:0] {IDLE = 2'b00, PRIME = 2'b01, RUN = 2'b10} st_t;

   st_t              st;
   logic [47:0]      mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [TW-1:0]    tone_cnt;
   logic             phase, empty, full, drop, push, underrun;
   logic [23:0]      head_l, head_r, tone_val;

   assign empty    = fill == '0;
   assign full     = fill == FULL_LV;
   assign {head_l, head_r} = mem[rd_ptr];
   assign read     = st != IDLE && read_ready;
   assign write    = st == RUN && write_ready && !empty;
   assign underrun = st == RUN && write_ready && empty;
   // a full FIFO still accepts a pair when the head leaves in the same cycle
   assign drop     = read && full && !write;
   assign push     = read && !drop;
   assign tone_val = phase ? TONE_AMP : ~TONE_AMP + 24'd1;
   assign state    = st;

   assign writedata_left  = (!write || mode == 2'b01) ? '0 :
                            (mode == 2'b10) ? tone_val :
                            (mode == 2'b11) ? head_r : head_l;
   assign writedata_right = (!write || mode == 2'b01) ? '0 :
                            (mode == 2'b10) ? tone_val :
                            (mode == 2'b11) ? head_l : head_r;

   always_ff @(posedge CLOCK_50)
      if (push) mem[wr_ptr] <= {readdata_left, readdata_right};

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         st           <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fill         <= '0;
         overflow_cnt <= '0;
         underrun_cnt <= '0;
         tone_cnt     <= '0;
         phase        <= 1'b1;
      end else begin
         if (!enable || st == IDLE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (write) rd_ptr <= rd_ptr + AW'(1);
            fill <= fill + (AW+1)'(push) - (AW+1)'(write);
         end
         if (drop && overflow_cnt != '1) overflow_cnt <= overflow_cnt + CNT_W'(1);
         if (underrun && underrun_cnt != '1) underrun_cnt <= underrun_cnt + CNT_W'(1);
         if (write && mode == 2'b10) begin
            tone_cnt <= (tone_cnt == TONE_LAST) ? '0 : tone_cnt + TW'(1);
            if (tone_cnt == TONE_LAST) phase <= ~phase;
         end
         st <= !enable ? IDLE :
               (st == IDLE) ? PRIME :
               (st == PRIME && fill >= PRIME_LV) ? RUN :
               (st == RUN && underrun) ? PRIME : st;
      end
   end
endmodule

// File: doc/audio_stream_ctrl.md
Name: audio_stream_ctrl

Overview:
- Sequences the audio codec read/write handshake between the codec's readdata and writedata ports.
- Buffers stereo sample pairs in an internal FIFO, primes it to a fill level before playback, and selects the output source: passthrough, mute, test tone or L/R swap.
- Counts overflow and underrun events.
- Sits between audio_codec and any downstream effect logic; replaces the bare read/write glue in the top level.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, >=4); each entry is {left[23:0], right[23:0]}.
- PRIME_LEVEL, 8, fill level (1..DEPTH) required before writes start.
- TONE_HALF, 24, write events per tone half-period (about 1 kHz at 48 kHz).
- TONE_AMP, 24'h200000, tone amplitude; the tone outputs +TONE_AMP or -TONE_AMP (two's complement).
- CNT_W, 16, event counter width.

Ports:
- CLOCK_50  in  1  system clock; all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  0 = idle and flush; 1 = stream.
- mode  in  2  00 passthrough, 01 mute, 10 tone, 11 swap L/R.
- read_ready  in  1  codec has an ADC sample pair.
- write_ready  in  1  codec can accept a DAC sample pair.
- readdata_left  in  24  codec ADC left.
- readdata_right  in  24  codec ADC right.
- read  out  1  consume codec ADC pair this cycle.
- write  out  1  send writedata pair this cycle.
- writedata_left  out  24  DAC left.
- writedata_right  out  24  DAC right.
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy.
- state  out  2  00 IDLE, 01 PRIME, 10 RUN.
- overflow_cnt  out  CNT_W  saturating count of dropped ADC pairs.
- underrun_cnt  out  CNT_W  saturating count of underruns.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, FIFO empty, fill=0, counters=0, tone phase=positive, tone counter=0.
  - read=0, write=0, writedata=0.
- read and write are combinational from registered state, FIFO flags and the ready inputs. Each is a one-cycle pulse per transfer; the codec samples it on the same edge.
- FIFO:
  - Show-ahead; the head is visible with 0 latency.
  - push = read & !drop; pop = write.
  - Push and pop in the same cycle are allowed. A push when full is accepted only if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH; fill updates on the next edge.
- IDLE:
  - read=0, write=0; FIFO flushed each cycle.
  - Transition: enable=1 -> PRIME.
- PRIME:
  - read = read_ready.
  - write=0.
  - Transition: fill >= PRIME_LEVEL (registered fill) -> RUN.
- RUN:
  - read = read_ready.
  - write = write_ready & !empty.
  - Underrun: write_ready & empty -> no write, underrun_cnt+1, next state PRIME.
- Overflow:
  - Condition: read_ready while full and no pop this cycle.
  - read is still asserted so the codec does not stall. The pair is dropped (drop=1, no push), overflow_cnt+1.
- enable=0 in any state -> IDLE on the next edge. The FIFO is flushed; counters are retained.
- Counters saturate at all-ones. They clear only on reset.
- writedata by mode, with H = FIFO head:
  - 00: left=H.left, right=H.right.
  - 01: 0/0.
  - 11: left=H.right, right=H.left.
  - 10: both channels = phase ? TONE_AMP : -TONE_AMP.
- All modes pop the FIFO on write, so timing is identical across modes.
- Tone counter:
  - Increments on each write in mode 10.
  - At TONE_HALF-1 it wraps to 0 and toggles the phase.
  - Outside mode 10 it holds.
- writedata is driven 0 whenever write=0.
- mode changes take effect on the next write; no glitch requirement otherwise.
- Simultaneous underrun and read_ready in RUN: the push occurs and the state goes to PRIME (fill becomes 1).
- reset_n asserted mid-transfer: outputs go to their reset values immediately (async). A pending transfer is abandoned.

Test Plan:
- Priming: reset, enable=1, mode=00, read_ready pulses carrying L=i, R=0x100+i, write_ready held 1.
  - Required: write=0 until the 8th push is registered; first write carries L=0, R=0x100; output stays in order.
  - Required: state 01 -> 10.
- Overflow: DEPTH=16, write_ready=0, 20 read pulses.
  - Required: fill=16; overflow_cnt=4; read asserted on all 20.
  - Required: on draining, the first 16 pairs are output unchanged.
- Underrun: in RUN with fill=1, write_ready held 1, read_ready=0.
  - Required: one write, then underrun_cnt=1 and state=PRIME; write stays 0 until fill reaches 8.
- Tone: mode=10, TONE_HALF=24, 100 writes.
  - Required: writes 0..23 = 0x200000 on both channels; writes 24..47 = 0xE00000; FIFO pops each write.
- Swap/mute: mode=11 with head L=0xABCDEF, R=0x123456 -> writedata L=0x123456, R=0xABCDEF. mode=01 -> 0/0, fill decrements.
- Disable/reset: enable=0 in RUN with fill=5 -> next cycle state=IDLE, fill=0, read=write=0. reset_n low mid-stream -> all outputs 0 asynchronously; counters cleared.
